elastic_buffer: RTL and testbench
=================================

Name: elastic_buffer

Overview:
- Parametrised successor to the two-entry skid buffer: a DEPTH-word ready/valid elastic buffer.
- i_ready and o_valid are registered, and o_data is driven from a register.
- Adds an occupancy count, an almost-full flag and a synchronous flush.
- Sits between stream producers and consumers wherever timing must be cut on both the data and handshake paths and more than one word of slack is needed.

Parameters:
- WORD_WIDTH, 8, data word width in bits (>=1).
- DEPTH, 4, total word capacity including the output register (>=2; need not be a power of two).
- ALMOST_FULL_LEVEL, DEPTH-1, count at or above which almost_full asserts (1..DEPTH).

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- i_valid  in  1  upstream word valid.
- i_ready  out  1  registered; buffer can accept a word this cycle.
- i_data  in  WORD_WIDTH  upstream word.
- o_valid  out  1  registered; o_data holds a valid word.
- o_ready  in  1  downstream accepts o_data this cycle.
- o_data  out  WORD_WIDTH  registered output word.
- flush  in  1  synchronous; discard all stored words.
- count  out  $clog2(DEPTH+1)  registered occupancy, 0..DEPTH.
- almost_full  out  1  registered; count >= ALMOST_FULL_LEVEL.

Behaviour:
- Reset (reset_n low, asynchronous assert, synchronous release):
  - o_valid=0, i_ready=1, count=0, almost_full=0, o_data=0, read/write pointers=0.
  - i_valid is ignored while reset_n is low.
- Handshakes:
  - insert = i_valid & i_ready.
  - remove = o_valid & o_ready.
  - Upstream must hold i_data and i_valid stable while i_valid & !i_ready.
  - Buffer guarantees o_data and o_valid stable while o_valid & !o_ready.
- Storage:
  - Output register plus a (DEPTH-1)-entry circular store.
  - Words leave in strict arrival order.
- Occupancy: count_next = count + insert - remove, or 0 on flush.
- Flags:
  - i_ready <= (count_next < DEPTH).
  - o_valid <= (count_next != 0).
  - almost_full <= (count_next >= ALMOST_FULL_LEVEL).
  - All flags are computed from count_next, so they are correct one cycle after any event, with no combinational path from inputs to outputs.
- Datapath cases:
  - Output empty (or being removed) and store empty, with insert: i_data loads the output register.
  - Latency is one cycle: a word accepted at edge N is visible on o_data after edge N.
  - Output occupied and not removed, with insert: i_data is written to store[wr_ptr].
  - Remove with store non-empty: the output register loads store[rd_ptr]. If insert also occurs, i_data is written to store[wr_ptr] in the same cycle.
  - Remove with store empty and no insert: output register holds its value; o_valid falls.
- Pointers advance modulo DEPTH-1 with explicit wrap (DEPTH-2 -> 0). Power-of-two wrap is not assumed.
- Full (count==DEPTH):
  - i_ready=0, so a simultaneous insert cannot occur.
  - Remove at full gives count DEPTH-1 and i_ready=1 on the next cycle.
- Empty (count==0): o_valid=0. A remove cannot occur; o_ready is ignored.
- Flush has highest priority:
  - Any insert or remove in the same cycle is discarded. The upstream handshake still completes, and that word is dropped.
  - Next cycle: count=0, o_valid=0, i_ready=1, almost_full=0, pointers=0. o_data keeps its old value.
- Reset asserted mid-transfer: all contents are lost immediately and flags return to reset values asynchronously.
- Unreachable: count>DEPTH. Formal asserts count<=DEPTH and that count equals the number of words accepted minus the number removed since the last reset or flush.

Decomposition:
- Package elastic_buffer_pkg:
  - function count_width(depth) returning $clog2(depth+1).
  - function ptr_wrap(ptr, depth) returning (ptr==depth-2) ? 0 : ptr+1.
- Sub-module elastic_buffer_store:
  - (DEPTH-1) x WORD_WIDTH circular store with wr_en, rd_en, wr_ptr/rd_ptr registers, and async active-low pointer reset.
  - Storage array has no reset.
- The top level holds the output register, count and flag registers, and the insert/remove/flush logic.
- The existing register module is not reused, because it resets synchronously.

Test Plan:
- Reset then i_valid=1, data 1..8, o_ready=1 continuously, DEPTH=4 -> o_data 1..8 in order, one word per cycle after a 1-cycle latency; count stays at 1; i_ready never drops.
- o_ready=0, push 1..5, DEPTH=4 -> 1..4 accepted; i_ready=0 after the 4th; count=4; almost_full=1 from count=3; word 5 held by upstream. Then o_ready=1 -> output 1,2,3,4,5 in order; i_ready rises one cycle after the first remove.
- DEPTH=5 (non-power-of-two), random i_valid/o_ready for 2000 cycles with incrementing data -> scoreboard matches; pointers wrap 3->0; stable-while-stalled assertions hold.
- Fill to count=3, then assert flush with i_valid=1 and data 0xAA -> next cycle count=0, o_valid=0, i_ready=1; 0xAA never appears on o_data.
- Fill to count=2, pull reset_n low mid-cycle -> o_valid=0, count=0, i_ready=1 immediately. After release, push 0x11 -> o_data=0x11 one cycle later.
- count=DEPTH, o_ready=1 and i_valid=1 for one cycle -> remove only (insert blocked); count=DEPTH-1; i_ready=1 next cycle.

Source files
------------

// File: rtl/elastic_buffer_pkg.sv
// Shared helpers for the elastic buffer: counter sizing and non-power-of-two
// circular pointer advance.
package elastic_buffer_pkg;

  function automatic int unsigned count_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  // Store holds depth-1 entries, so the last index is depth-2.
  function automatic int unsigned ptr_wrap(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 2) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/elastic_buffer_store.sv
// (DEPTH-1)-entry circular word store behind the elastic buffer output register.
// Pointers reset asynchronously; the storage array itself is never reset.
module elastic_buffer_store
  import elastic_buffer_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = 8,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [WORD_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [WORD_WIDTH-1:0] rd_data
);

  localparam int unsigned ENTRIES = DEPTH - 1;
  localparam int unsigned PW      = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  logic [WORD_WIDTH-1:0] mem [ENTRIES];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= PW'(ptr_wrap(32'(wr_ptr), DEPTH));
      if (rd_en) rd_ptr <= PW'(ptr_wrap(32'(rd_ptr), DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/elastic_buffer.sv
// DEPTH-word ready/valid elastic buffer with registered handshakes, registered
// output word, occupancy count, almost-full flag and synchronous flush.
module elastic_buffer
  import elastic_buffer_pkg::*;
#(
  parameter int unsigned WORD_WIDTH        = 8,
  parameter int unsigned DEPTH             = 4,
  parameter int unsigned ALMOST_FULL_LEVEL = DEPTH - 1
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          i_valid,
  output logic                          i_ready,
  input  logic [WORD_WIDTH-1:0]         i_data,
  output logic                          o_valid,
  input  logic                          o_ready,
  output logic [WORD_WIDTH-1:0]         o_data,
  input  logic                          flush,
  output logic [count_width(DEPTH)-1:0] count,
  output logic                          almost_full
);

  localparam int unsigned CW = count_width(DEPTH);

  logic                  insert;
  logic                  remove;
  logic                  store_empty;
  logic                  load_direct;
  logic                  wr_en;
  logic                  rd_en;
  logic [CW-1:0]         count_next;
  logic [WORD_WIDTH-1:0] store_rd_data;

  always_comb begin
    insert      = i_valid & i_ready;
    remove      = o_valid & o_ready;
    // o_valid tracks count != 0, so the store holds count-1 words when non-empty.
    store_empty = (count <= CW'(1));
    load_direct = 1'b0;
    wr_en       = 1'b0;
    rd_en       = 1'b0;
    count_next  = count + CW'(insert) - CW'(remove);
    if (flush) begin
      count_next = '0;
    end else begin
      load_direct = insert & (~o_valid | remove) & store_empty;
      wr_en       = insert & ~load_direct;
      rd_en       = remove & ~store_empty;
    end
  end

  elastic_buffer_store #(
    .WORD_WIDTH(WORD_WIDTH),
    .DEPTH     (DEPTH)
  ) u_store (
    .clk    (clk),
    .reset_n(reset_n),
    .flush  (flush),
    .wr_en  (wr_en),
    .wr_data(i_data),
    .rd_en  (rd_en),
    .rd_data(store_rd_data)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      o_data <= '0;
    end else if (rd_en) begin
      o_data <= store_rd_data;
    end else if (load_direct) begin
      o_data <= i_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count       <= '0;
      i_ready     <= 1'b1;
      o_valid     <= 1'b0;
      almost_full <= 1'b0;
    end else begin
      count       <= count_next;
      i_ready     <= (count_next < CW'(DEPTH));
      o_valid     <= (count_next != '0);
      almost_full <= (count_next >= CW'(ALMOST_FULL_LEVEL));
    end
  end

endmodule

// File: tb/tb_elastic_buffer.sv
// Randomised and directed bench for elastic_buffer against a queue-based model.
module tb_elastic_buffer;

  localparam int unsigned WW    = 8;
  localparam int unsigned DEPTH = 5;
  localparam int unsigned AFL   = DEPTH - 1;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          reset_n;
  logic          i_valid;
  logic          i_ready;
  logic [WW-1:0] i_data;
  logic          o_valid;
  logic          o_ready;
  logic [WW-1:0] o_data;
  logic          flush;
  logic [CW-1:0] count;
  logic          almost_full;

  elastic_buffer #(
    .WORD_WIDTH       (WW),
    .DEPTH            (DEPTH),
    .ALMOST_FULL_LEVEL(AFL)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_valid    (i_valid),
    .i_ready    (i_ready),
    .i_data     (i_data),
    .o_valid    (o_valid),
    .o_ready    (o_ready),
    .o_data     (o_data),
    .flush      (flush),
    .count      (count),
    .almost_full(almost_full)
  );

  always #5 clk = ~clk;

  int            n_vec = 0;
  int            n_err = 0;
  logic [WW-1:0] q[$];
  logic [WW-1:0] exp_odata;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".count"},       32'(count),       32'(q.size()));
    check({tag, ".o_valid"},     32'(o_valid),     32'(q.size() != 0));
    check({tag, ".i_ready"},     32'(i_ready),     32'(q.size() < DEPTH));
    check({tag, ".almost_full"}, 32'(almost_full), 32'(q.size() >= AFL));
    check({tag, ".o_data"},      32'(o_data),      32'(exp_odata));
  endtask

  // One clock: drive at negedge, predict the handshakes from the model, check after the edge.
  task automatic cycle(input string tag, input logic iv, input logic [WW-1:0] id,
                       input logic ordy, input logic fl, output logic accepted);
    logic ins, rem;
    @(negedge clk);
    i_valid = iv;
    i_data  = id;
    o_ready = ordy;
    flush   = fl;
    ins = iv && (q.size() < DEPTH);
    rem = ordy && (q.size() != 0);
    @(posedge clk);
    #1;
    if (fl) begin
      q.delete();
    end else begin
      if (rem) void'(q.pop_front());
      if (ins) q.push_back(id);
    end
    if (q.size() != 0) exp_odata = q[0];
    accepted = ins;
    check_outputs(tag);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

  initial begin
    logic          acc;
    logic [WW-1:0] w;
    logic          pend;
    logic          rv, rr, rf;

    reset_n   = 1'b0;
    i_valid   = 1'b1;
    i_data    = 8'h77;
    o_ready   = 1'b0;
    flush     = 1'b0;
    exp_odata = '0;
    #22;
    check_outputs("reset");
    @(negedge clk);
    reset_n = 1'b1;
    i_valid = 1'b0;

    // Continuous stream: one-cycle latency, occupancy stays at 1.
    for (int k = 1; k <= 8; k++) cycle("stream", 1'b1, WW'(k), 1'b1, 1'b0, acc);
    cycle("stream_tail", 1'b0, '0, 1'b1, 1'b0, acc);

    // Fill with downstream stalled; the word past capacity is held upstream.
    w = 8'd1;
    for (int k = 0; k < DEPTH + 2; k++) begin
      cycle("fill", 1'b1, w, 1'b0, 1'b0, acc);
      if (acc) w++;
    end
    // Drain at full with i_valid held: first cycle is remove-only.
    for (int k = 0; k < DEPTH + 4; k++) begin
      cycle("drain", (w <= DEPTH + 1), w, 1'b1, 1'b0, acc);
      if (acc) w++;
    end

    // Flush with a concurrent insert: 0xAA is dropped.
    for (int k = 0; k < 3; k++) cycle("pre_flush", 1'b1, 8'h30 + WW'(k), 1'b0, 1'b0, acc);
    cycle("flush", 1'b1, 8'hAA, 1'b1, 1'b1, acc);
    for (int k = 0; k < 3; k++) cycle("post_flush", 1'b0, '0, 1'b1, 1'b0, acc);
    cycle("post_flush_push", 1'b1, 8'h42, 1'b1, 1'b0, acc);
    cycle("post_flush_pop", 1'b0, '0, 1'b1, 1'b0, acc);

    // Asynchronous reset in the middle of a cycle.
    for (int k = 0; k < 2; k++) cycle("pre_reset", 1'b1, 8'h60 + WW'(k), 1'b0, 1'b0, acc);
    #2;
    reset_n = 1'b0;
    q.delete();
    exp_odata = '0;
    #1;
    check_outputs("async_reset");
    @(negedge clk);
    i_valid = 1'b1;
    i_data  = 8'h99;
    @(posedge clk);
    #1;
    check_outputs("reset_held");
    @(negedge clk);
    reset_n = 1'b1;
    i_valid = 1'b0;
    cycle("after_reset", 1'b1, 8'h11, 1'b0, 1'b0, acc);
    cycle("after_reset_pop", 1'b0, '0, 1'b1, 1'b0, acc);

    // Random traffic, upstream holds a word until accepted, rare flushes.
    w    = '0;
    pend = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      rv = pend ? 1'b1 : ($urandom_range(0, 3) != 0);
      rr = ($urandom_range(0, 2) != 0);
      rf = ($urandom_range(0, 99) == 0);
      cycle("random", rv, w, rr, rf, acc);
      pend = rv && !acc;
      if (acc) w++;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
